// File: rtl/gate_sequence_detector.sv
// -----------------------------------------------------------------------------
// gate_sequence_detector
//
// Front end of the queue occupancy counter. The two entrance photocells are
// synchronised and debounced. A passage FSM then follows a person through the
// gate and emits single-cycle entry (inc) and exit (dec) pulses. Illegal
// sensor sequences raise a single-cycle err pulse.
//
// Optional feature: define GATE_DET_TIMEOUT_EN to abort a passage that makes no
// progress for TIMEOUT_CYCLES cycles. The abort pulses err and parks the FSM in
// WAIT_CLEAR. Without the macro, the FSM waits indefinitely in any
// intermediate state.
//
// Parameters
//   SYNC_STAGES      flip-flops per sensor synchroniser (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a change (>= 1)
//   TIMEOUT_CYCLES   no-progress limit, used only with GATE_DET_TIMEOUT_EN (>= 1)
//
// Ports
//   clk     clock
//   rst     synchronous, active-high reset
//   sens_a  outer photocell, 1 = beam blocked, asynchronous
//   sens_b  inner photocell, 1 = beam blocked, asynchronous
//   inc     one-cycle pulse when an entry completes
//   dec     one-cycle pulse when an exit completes
//   err     one-cycle pulse on an illegal sequence or a timeout
//   busy    high while the FSM is not in IDLE
// -----------------------------------------------------------------------------
module gate_sequence_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_a,
  input  logic sens_b,
  output logic inc,
  output logic dec,
  output logic err,
  output logic busy
);

  // Elaboration-time parameter guards
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("gate_sequence_detector: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("gate_sequence_detector: DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("gate_sequence_detector: TIMEOUT_CYCLES must be at least 1");
  end

  // The debounce counter only has to count up to DEBOUNCE_CYCLES-1. On the
  // next differing cycle the new value is accepted and the counter restarts.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_A       = 3'd1,
    IN_AB      = 3'd2,
    IN_B       = 3'd3,
    OUT_B      = 3'd4,
    OUT_BA     = 3'd5,
    OUT_A      = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  // Bit 1 carries sensor A and bit 0 carries sensor B, so db_p1 reads directly
  // as the AB code used in the transition table.
  logic [1:0] raw;
  logic [1:0] db_p1;
  logic       db_a;
  logic       db_b;

  assign raw  = {sens_a, sens_b};
  assign db_a = db_p1[1];
  assign db_b = db_p1[0];

  // ---------------------------------------------------------------------------
  // Stage p0: synchroniser chain. Stage p1: debouncer. One of each per sensor.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < 2; i++) begin : g_sens
    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   db_q;
    logic                   sync_out;

    assign sync_out = sync_p0[SYNC_STAGES-1];
    assign db_p1[i] = db_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= '0;
        cnt_p1  <= '0;
        db_q    <= 1'b0;
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw[i]};
        if (sync_out == db_q) begin
          // Any agreeing cycle restarts the stability count.
          cnt_p1 <= '0;
        end else if (cnt_p1 == DB_LAST) begin
          cnt_p1 <= '0;
          db_q   <= sync_out;
        end else begin
          cnt_p1 <= cnt_p1 + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: passage FSM with registered pulse outputs
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic       inc_nxt;
  logic       dec_nxt;
  logic       err_nxt;
  logic [1:0] ab;

  assign ab = {db_a, db_b};

`ifdef GATE_DET_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr;
  logic             tracking;

  // The timer runs only while a passage is in progress. IDLE and WAIT_CLEAR
  // are legitimate resting states.
  assign tracking = (state != IDLE) && (state != WAIT_CLEAR);
`endif

  always_comb begin
    state_nxt = state;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = IN_A;
          2'b01:   state_nxt = OUT_B;
          2'b11: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end

      IN_A: begin
        case (ab)
          2'b11:   state_nxt = IN_AB;
          2'b00:   state_nxt = IDLE;   // balk: person stepped back out
          2'b01: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = IN_A;
        endcase
      end

      IN_AB: begin
        case (ab)
          2'b01:   state_nxt = IN_B;
          2'b10:   state_nxt = IN_A;
          2'b00: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = IN_AB;
        endcase
      end

      IN_B: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            inc_nxt   = 1'b1;
          end
          2'b11:   state_nxt = IN_AB;
          2'b10: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = IN_B;
        endcase
      end

      OUT_B: begin
        case (ab)
          2'b11:   state_nxt = OUT_BA;
          2'b00:   state_nxt = IDLE;
          2'b10: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = OUT_B;
        endcase
      end

      OUT_BA: begin
        case (ab)
          2'b10:   state_nxt = OUT_A;
          2'b01:   state_nxt = OUT_B;
          2'b00: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = OUT_BA;
        endcase
      end

      OUT_A: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            dec_nxt   = 1'b1;
          end
          2'b11:   state_nxt = OUT_BA;
          2'b01: begin
            state_nxt = WAIT_CLEAR;
            err_nxt   = 1'b1;
          end
          default: state_nxt = OUT_A;
        endcase
      end

      WAIT_CLEAR: begin
        if (ab == 2'b00) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

`ifdef GATE_DET_TIMEOUT_EN
    // A real sensor transition in the same cycle takes precedence over the
    // timeout, because that transition also restarts the timer.
    if (tracking && (state_nxt == state) && (tmr == TMR_LAST)) begin
      state_nxt = WAIT_CLEAR;
      err_nxt   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inc   <= 1'b0;
      dec   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      inc   <= inc_nxt;
      dec   <= dec_nxt;
      err   <= err_nxt;
      // busy follows the registered state, so it drops in the same cycle as
      // the completing pulse.
      busy  <= (state_nxt != IDLE);
    end
  end

`ifdef GATE_DET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || !tracking || (state_nxt != state)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_gate_sequence_detector
//
// Scoreboard bench for gate_sequence_detector. At the moment each pattern is
// applied, the bench pushes the pulse (kind and cycle) that the pattern should
// produce. A monitor pops and compares every inc/dec/err pulse it sees.
// Compile with GATE_DET_TIMEOUT_EN defined to expect the timeout abort.
// -----------------------------------------------------------------------------
module tb_gate_sequence_detector;

  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int TC  = 64;
  localparam int LAT = SS + DC + 1;

  localparam int K_INC = 1;
  localparam int K_DEC = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic inc;
  logic dec;
  logic err;
  logic busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  gate_sequence_detector #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sens_a(sens_a),
    .sens_b(sens_b),
    .inc   (inc),
    .dec   (dec),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int kind, input int delay);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + delay;
    sb.push_back(e);
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    sens_a = a;
    sens_b = b;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (inc || dec || err)) begin
      int   kind;
      exp_t e;
      kind = inc ? K_INC : (dec ? K_DEC : K_ERR);
      chk("excl", int'(inc) + int'(dec) + int'(err), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", kind, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5);

    // Entry: 10, 11, 01, 00
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    expect_pulse(K_INC, LAT);
    drive(1'b0, 1'b0, 20);
    chk("entry_pending", sb.size(), 0);
    chk("entry_busy", int'(busy), 0);

    // Exit: 01, 11, 10, 00
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    expect_pulse(K_DEC, LAT);
    drive(1'b0, 1'b0, 20);
    chk("exit_pending", sb.size(), 0);
    chk("exit_busy", int'(busy), 0);

    // Balk: A blocked then released; busy rises and falls with no pulse
    seen = 0;
    sens_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    drive(1'b0, 1'b0, 20);
    chk("balk_busy_seen", seen, 1);
    chk("balk_busy_end", int'(busy), 0);
    chk("balk_pending", sb.size(), 0);

    // Glitch: a 3-cycle pulse on sens_a is rejected
    drive(1'b1, 1'b0, 3);
    seen = 0;
    sens_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch_busy", seen, 0);

    // Illegal: both sensors together from IDLE, then 01, then 00
    expect_pulse(K_ERR, LAT);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 20);
    chk("illegal_pending", sb.size(), 0);
    chk("illegal_busy", int'(busy), 0);

    // Timeout: A held for 100 cycles
`ifdef GATE_DET_TIMEOUT_EN
    expect_pulse(K_ERR, LAT + TC);
`endif
    drive(1'b1, 1'b0, 100);
    drive(1'b0, 1'b0, 20);
    chk("timeout_pending", sb.size(), 0);
    chk("timeout_busy", int'(busy), 0);

    // Reset mid-passage in IN_AB
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    chk("midrst_pre_busy", int'(busy), 1);
    rst    = 1'b1;
    sens_a = 1'b0;
    sens_b = 1'b0;
    @(negedge clk);
    chk("midrst_inc", int'(inc), 0);
    chk("midrst_dec", int'(dec), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 20);
    chk("midrst_after_busy", int'(busy), 0);
    chk("midrst_pending", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
